// File: rtl/palindrome_pkg.sv
// Types shared by the serial packer and the downstream bit-reversal stage.
package palindrome_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/word_output_buffer.sv
// Single-entry valid/ready holding register with sticky overrun detection.
module word_output_buffer
  import palindrome_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             overrun
);

  buf_state_t state;

  // valid decodes the state register only, so ready never reaches it combinationally
  assign valid = (state == BUF_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BUF_EMPTY;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (load) begin
            data  <= load_data;
            state <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (load && ready) begin
            data <= load_data;
          end else if (load) begin
            overrun <= 1'b1;
          end else if (ready) begin
            state <= BUF_EMPTY;
          end
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_packer.sv
// Packs a serial bit stream into WIDTH-bit words behind a single-entry output register.
module serial_word_packer
  import palindrome_pkg::*;
#(
  parameter int unsigned WIDTH     = WORD_W,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_start,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             overrun,
  output logic             partial_drop,
  output logic [15:0]      word_count
);

  localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] pos;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] assembled;
  logic             complete;
  logic             handshake;

  // frame_start restarts the word at this very bit, so indexing uses idx rather than cnt
  always_comb begin
    idx            = frame_start ? '0 : cnt;
    pos            = LSB_FIRST ? idx : LAST - idx;
    assembled      = shreg;
    assembled[pos] = bit_in;
    complete       = bit_valid && (idx == LAST);
  end

  assign handshake = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      shreg        <= '0;
      partial_drop <= 1'b0;
      word_count   <= '0;
    end else begin
      if (frame_start && (cnt != '0)) begin
        partial_drop <= 1'b1;
      end
      if (bit_valid) begin
        shreg <= assembled;
        cnt   <= complete ? '0 : idx + 1'b1;
      end else if (frame_start) begin
        cnt <= '0;
      end
      if (handshake) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

  word_output_buffer #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (complete),
    .load_data(assembled),
    .ready    (word_ready),
    .valid    (word_valid),
    .data     (word_out),
    .overrun  (overrun)
  );

endmodule

// File: doc/serial_word_packer.md
# serial_word_packer

Upstream feeder for the bit-reversal/palindrome stage. Accepts a serial bit stream one bit per qualified cycle and packs each run of WIDTH bits into a parallel word. Holds each completed word in a single-entry output register behind a valid/ready handshake, so the stage downstream (whose `input_value` port is 32 bits) can stall without stalling reception. Reports overruns and discarded partial words.

## Interface
- `WIDTH`, 32: word width in bits; must equal the downstream `input_value` width.
- `LSB_FIRST`, 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_valid`  in  1  `bit_in` is meaningful this cycle.
- `bit_in`  in  1  serial data bit.
- `frame_start`  in  1  discard any partial word; with `bit_valid` high, this cycle's bit becomes bit index 0 of a new word.
- `word_valid`  out  1  `word_out` holds a completed word.
- `word_ready`  in  1  downstream accepts the word this cycle.
- `word_out`  out  WIDTH  packed word; stable while `word_valid` is high and `word_ready` is low.
- `overrun`  out  1  sticky; a completed word was dropped because the output register was full.
- `partial_drop`  out  1  sticky; `frame_start` discarded a nonzero partial word.
- `word_count`  out  16  completed words accepted by downstream; wraps 0xFFFF→0.

## Operation
- Bit counter `cnt` runs 0..WIDTH-1 and is $clog2(WIDTH) bits wide. The shift register `shreg` is WIDTH bits wide.
- Accepted bit: a cycle with `bit_valid`=1. The bit goes to position `cnt` (LSB_FIRST=1) or WIDTH-1-`cnt` (LSB_FIRST=0), and `cnt` increments.
- Completion: an accepted bit with `cnt`==WIDTH-1. The complete word, including this bit, is offered to the output register, and `cnt` returns to 0.
- Output register states:
  - EMPTY → FULL on completion.
  - FULL → EMPTY on a handshake (`word_valid` & `word_ready`) with no completion in the same cycle.
  - FULL stays FULL on handshake plus completion in the same cycle: the new word loads and there is no overrun.
  - FULL with completion and no handshake: the new word is dropped, `overrun` is set, and the held word is unchanged.
- `frame_start`=1:
  - `cnt` is forced so that this cycle's bit (if `bit_valid`) is index 0 and `cnt` becomes 1. Without `bit_valid`, `cnt` becomes 0.
  - If the old `cnt`≠0, `partial_drop` is set.
  - Has no effect on the output register.
- With WIDTH=1 every accepted bit completes a word, and `frame_start` never sets `partial_drop`.
- `word_count` increments on each handshake.
- `overrun` and `partial_drop` are cleared only by `rst`.

## Timing
- Reset values: `cnt`=0, `shreg`=0, output register EMPTY, `word_valid`=0, `word_out`=0, `overrun`=0, `partial_drop`=0, `word_count`=0.
- Latency: `word_valid` rises the cycle after the completing bit's edge, i.e. registered with one cycle of latency.
- Throughput: one bit per cycle is sustained indefinitely when downstream holds `word_ready`=1.
- `word_ready` may be asserted while `word_valid`=0; it has no effect then.
- `word_valid` never drops without a handshake, except on `rst`.
- No combinational path from `word_ready` to `word_valid` or `word_out`.
- Reset mid-word or mid-handshake: the next cycle is in the reset state; partial and held words are lost and no flags are set.

## Structure
- Shared package `palindrome_pkg`: `WORD_W`=32 and `typedef logic [WORD_W-1:0] word_t`. The downstream reversal stage uses the same types.
- Sub-module `word_output_buffer`: the single-entry valid/ready holding register. It has a load port and a drop indication, and contains the EMPTY/FULL logic and the overrun detection.
- Top level contains the bit counter, the shift register, the frame logic and `word_count`.

## Test plan
- Reset, then 32 bits LSB-first of 0x0000_0001 (first bit 1, then 31 zeros), `word_ready`=1 → `word_valid` one cycle after the 32nd bit, `word_out`=0x0000_0001, `word_count`=1.
- Same bit sequence with LSB_FIRST=0 → `word_out`=0x8000_0000.
- Back-to-back words 0xA5A5_A5A5 then 0x8000_0001 with `word_ready` tied to 0 → first word held, `overrun`=1 at completion of the second, `word_out` stays 0xA5A5_A5A5. Then `word_ready`=1 → one handshake, `word_valid` falls.
- Output FULL; handshake in the exact cycle of the next completion → second word loads, `overrun`=0, `word_valid` stays high, `word_count` increments by 1.
- 10 bits sent, then `frame_start` with `bit_valid`, then 31 more bits of 0xFFFF_FFFF → `partial_drop`=1, `word_out`=0xFFFF_FFFF, completion after exactly 32 post-frame bits.
- `rst` asserted after 20 bits with a FULL output → next cycle `word_valid`=0, `word_count`=0, flags 0. A following 32-bit word is packed from index 0.
